hp_add_arb: RTL
===============

Name: hp_add_arb

Overview:
Round-robin arbiter that shares one pipelined hp_add_vec vector adder among NUM_REQ requesters, such as several group accumulators or SSM reduction lanes. It accepts one add request per cycle through per-requester valid/ready, issues it to the adder, and tracks the requester tag of every in-flight add. When the adder returns a result, the block routes it back to the requester that issued it. The adder has fixed latency and no backpressure, so requesters must always accept results.

Parameters:
DW, 16, element width (fp16)
H_TILE, 1, heads per tile
P_TILE, 1, positions per tile
NUM_REQ, 4, number of requesters (2..8)
MAX_INFLIGHT, 4, tag-queue depth: maximum outstanding adds (power of 2, ≥1)
(local) HPW = H_TILE*P_TILE*DW; TW = max(1, clog2(NUM_REQ))

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset; synchronous, active-high (1 = reset) despite the codebase name
req_valid_i  in  NUM_REQ  per-requester add request
req_ready_o  out  NUM_REQ  one-hot grant; handshake when valid&ready
req_a_i  in  NUM_REQ*HPW  operand A; requester k occupies slice [k*HPW +: HPW]
req_b_i  in  NUM_REQ*HPW  operand B, same packing as req_a_i
add_valid_o  out  1  fire strobe to hp_add_vec valid_i
add_a_o  out  HPW  adder operand A
add_b_o  out  HPW  adder operand B
add_y_i  in  HPW  adder result
add_v_i  in  1  adder result valid
res_valid_o  out  NUM_REQ  one-hot result strobe to the owning requester
res_y_o  out  HPW  result data, shared by all requesters
inflight_o  out  clog2(MAX_INFLIGHT)+1  outstanding adds (tag-queue count)
err_o  out  1  sticky: add_v_i arrived with the tag queue empty

Behaviour:
- Reset (rstn=1 at posedge): all outputs 0; rr_ptr=0; tag queue empty (head=tail=count=0); err_o=0. Reset mid-operation discards every tag. Any add_v_i after reset with the queue empty sets err_o.
- Grant is combinational from req_valid_i, rr_ptr and can_issue:
  - can_issue = (count < MAX_INFLIGHT) || add_v_i. A same-cycle retire frees the slot.
  - Scan requesters rr_ptr, rr_ptr+1, … mod NUM_REQ; the first with valid set gets req_ready_o=1. At most one bit is set.
  - If can_issue=0, all ready bits are 0.
  - Ready never depends on a requester's own valid except through the scan.
- On handshake with requester g:
  - Next cycle: add_valid_o=1 and add_a_o/add_b_o = slice g of req_a_i/req_b_i.
  - Tag g is pushed at tail.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - With no handshake, add_valid_o=0, add_a_o/add_b_o hold their last values, and rr_ptr holds.
- On add_v_i=1 with count>0:
  - Pop the tag t at head.
  - Next cycle: res_valid_o = one-hot(t) and res_y_o = add_y_i.
  - Otherwise res_valid_o=0 and res_y_o holds.
- On add_v_i=1 with count=0: no pop, no res_valid_o; err_o <= 1 and stays set until reset.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo MAX_INFLIGHT.
- Ordering: hp_add_vec has fixed latency, so results return in issue order and FIFO tags are sufficient.
- Latency: handshake at cycle T → add_valid_o at T+1 → add_v_i at T+1+ADD_LAT → res_valid_o at T+2+ADD_LAT.
- Throughput: 1 add/cycle sustained when MAX_INFLIGHT ≥ ADD_LAT+1. Below that depth, issue stalls with ready=0 until a retire.
- inflight_o = count, registered.
- No arithmetic is performed in this block; data passes through bit-exact.

Test Plan:
- Single requester: req 1 valid with A=0x3C00 (1.0), B=0x4000 (2.0), model adder ADD_LAT=2. Ready[1]=1 at T; add_valid_o at T+1; res_valid_o=4'b0010 with res_y_o=0x4200 (3.0) at T+4; inflight returns to 0.
- Round-robin fairness: all 4 requesters held valid for 8 cycles starting with rr_ptr=0. Grant order is 0,1,2,3,0,1,2,3, and each requester receives exactly 2 res_valid pulses, in that order.
- Full stall: MAX_INFLIGHT=2, ADD_LAT=4, requester 0 continuously valid. Ready is high for 2 cycles, then low until the first add_v_i, and inflight_o never exceeds 2.
- Simultaneous retire/issue: queue full (count=MAX_INFLIGHT) while add_v_i=1 and req 2 valid. The grant is issued that cycle, count stays at MAX_INFLIGHT, and the tag order stays intact.
- Error: after reset with no issues, pulse add_v_i=1. err_o=1 next cycle and stays set, with res_valid_o=0. Asserting rstn clears it to 0.
- Reset mid-flight: 3 adds outstanding, assert rstn for 1 cycle. All outputs and inflight_o are 0 and rr_ptr=0. A following request from req 3 is granted and returns its result to req 3 only.

Source files
------------

// File: rtl/hp_add_arb.sv
// hp_add_arb
// Round-robin arbiter that shares one pipelined hp_add_vec adder between
// NUM_REQ requesters. Each accepted request is issued to the adder on the
// next cycle. The requester index (tag) goes into a FIFO. When the adder
// returns a result, the oldest tag is popped and the result goes back to
// that requester. Because the adder has a fixed latency, results come back
// in issue order, so a FIFO of tags is enough to route them.
//
// Ports
//   clk          clock, rising edge
//   rstn         synchronous reset, active HIGH (1 = reset)
//   req_valid_i  per-requester add request
//   req_ready_o  one-hot grant (combinational); handshake = valid & ready
//   req_a_i      operand A, requester k at [k*HPW +: HPW]
//   req_b_i      operand B, same packing
//   add_valid_o  issue strobe to the adder
//   add_a_o      adder operand A (holds when idle)
//   add_b_o      adder operand B (holds when idle)
//   add_y_i      adder result
//   add_v_i      adder result valid
//   res_valid_o  one-hot result strobe to the owning requester
//   res_y_o      result data shared by all requesters (holds when idle)
//   inflight_o   outstanding adds (tag FIFO occupancy)
//   err_o        sticky: a result arrived while no add was outstanding

module hp_add_arb #(
    parameter int DW           = 16,
    parameter int H_TILE       = 1,
    parameter int P_TILE       = 1,
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int HPW = H_TILE * P_TILE * DW,
    localparam int TW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW  = $clog2(MAX_INFLIGHT) + 1,
    localparam int PW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*HPW-1:0] req_a_i,
    input  logic [NUM_REQ*HPW-1:0] req_b_i,
    output logic                   add_valid_o,
    output logic [HPW-1:0]         add_a_o,
    output logic [HPW-1:0]         add_b_o,
    input  logic [HPW-1:0]         add_y_i,
    input  logic                   add_v_i,
    output logic [NUM_REQ-1:0]     res_valid_o,
    output logic [HPW-1:0]         res_y_o,
    output logic [CW-1:0]          inflight_o,
    output logic                   err_o
);

    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] gnt_idx;
    logic          gnt_any;
    logic          can_issue;
    logic          push;
    logic          pop;
    int            scan_idx;

    logic [TW-1:0] tag_q [MAX_INFLIGHT];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        // Written as an explicit wrap so a depth of 1 still works
        // with a 1-bit pointer.
        return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // A retire in the same cycle frees a slot, so a full queue still
    // accepts a request while add_v_i is high.
    assign can_issue = (count < CW'(MAX_INFLIGHT)) || add_v_i;

    always_comb begin
        req_ready_o = '0;
        gnt_idx     = '0;
        gnt_any     = 1'b0;
        scan_idx    = 0;
        if (can_issue) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
                if (!gnt_any && req_valid_i[scan_idx]) begin
                    gnt_any               = 1'b1;
                    gnt_idx               = TW'(scan_idx);
                    req_ready_o[scan_idx] = 1'b1;
                end
            end
        end
    end

    assign push = gnt_any;
    // A result that arrives with nothing outstanding is flagged and
    // otherwise dropped. A push in the same cycle does not change this.
    assign pop  = add_v_i && (count != '0);

    assign inflight_o = count;

    // Tag storage has no reset. Reset clears the occupancy, which
    // makes the old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail] <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            rr_ptr      <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            add_valid_o <= 1'b0;
            add_a_o     <= '0;
            add_b_o     <= '0;
            res_valid_o <= '0;
            res_y_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            add_valid_o <= push;
            if (push) begin
                add_a_o <= req_a_i[int'(gnt_idx)*HPW +: HPW];
                add_b_o <= req_b_i[int'(gnt_idx)*HPW +: HPW];
                tail    <= ptr_inc(tail);
                rr_ptr  <= TW'((int'(gnt_idx) + 1) % NUM_REQ);
            end

            res_valid_o <= '0;
            if (pop) begin
                res_valid_o <= NUM_REQ'(1) << tag_q[head];
                res_y_o     <= add_y_i;
                head        <= ptr_inc(head);
            end

            if (add_v_i && (count == '0)) begin
                err_o <= 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
